// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: reset vector, NOP encoding, fetch FSM
// states, immediate-type encodings used by decode, and the fetch queue entry.
// FETCH_MISALIGN_TRAP_EN adds a misalignment flag to each queue entry.
package rv32i_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_t;

    typedef struct packed {
`ifdef FETCH_MISALIGN_TRAP_EN
        logic        misalign;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Immediate format selected by the major opcode; everything else is I-type.
    function automatic imm_type_t imm_type_of(input logic [6:0] opcode);
        imm_type_t t;
        case (opcode)
            7'b0100011:             t = IMM_S;
            7'b1100011:             t = IMM_B;
            7'b0110111, 7'b0010111: t = IMM_U;
            7'b1101111:             t = IMM_J;
            default:                t = IMM_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fetch_unit_rv32i_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirect)
// and decode. master = fetch unit side, slave = surrounding pipeline/memory.
// FETCH_MISALIGN_TRAP_EN adds instr_misalign.
interface fetch_unit_rv32i_if #(
    parameter int FQ_DEPTH = 2
);
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [31:0]      imem_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [31:0]      instr_pc;
    logic [24:0]      trimmed_instr;
    logic [CNT_W-1:0] fq_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic             instr_misalign;
`endif

    modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
        output instr_misalign,
`endif
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
               trimmed_instr, fq_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
        input  instr_misalign,
`endif
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
               trimmed_instr, fq_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_queue_rv32i.sv
// In-order {pc, instr} queue between fetch and decode with push, pop and a
// clear that may coincide with a push (the pushed entry survives the clear).
module fetch_queue_rv32i
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  fq_entry_t                i_data,
    output fq_entry_t                o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_full;

    assign w_wr_idx = i_clear ? '0 : r_wr;
    assign w_full   = (r_cnt == CNT_W'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_count  = r_cnt;
    assign o_head   = o_empty ? '0 : r_mem[r_rd];

    // Pointer and occupancy bookkeeping; a clear restarts the queue at slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_rd  <= '0;
            r_wr  <= i_push ? PTR_W'(1) : '0;
            r_cnt <= i_push ? CNT_W'(1) : '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage, written only on push; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[w_wr_idx] <= i_data;
    end

    // Upstream credit accounting makes a push into a full, non-draining queue impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_clear && w_full));

endmodule

// File: rtl/fetch_unit_rv32i.sv
// RV32I fetch stage: owns the PC, issues word requests under a credit limit
// of FQ_DEPTH (queued + outstanding), buffers responses in fetch_queue_rv32i
// and hands them to decode. Redirects flush the queue and drop stale
// in-flight responses (FLUSH state until they have all returned).
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target
// enqueues a flagged NOP and halts fetch until the next redirect; without it
// redirect targets are forced to word alignment.
module fetch_unit_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          FQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_rv32i_if.master bus
);
    localparam int              CNT_W   = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FQ_DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_rsp_pc;
    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] w_out_after;
    logic [CNT_W-1:0] w_drop_nxt;
    logic [CNT_W-1:0] w_fq_count;
    logic [31:0]      w_redir_pc;
    logic             w_redirect;
    logic             w_misalign;
    logic             w_halt;
    logic             w_rsp;
    logic             w_credit;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    fq_entry_t        w_push_data;
    fq_entry_t        w_head;

    assign w_redirect = bus.redirect_valid;
    assign w_rsp      = bus.imem_rsp_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_halt;

    assign w_redir_pc = bus.redirect_pc;
    assign w_misalign = |bus.redirect_pc[1:0];
    assign w_halt     = r_halt;

    // Halt latch: set by a misaligned redirect, released by an aligned one.
    always_ff @(posedge clk) begin
        if (!rst_n)          r_halt <= 1'b0;
        else if (w_redirect) r_halt <= w_misalign;
    end
`else
    assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    assign w_misalign = 1'b0;
    assign w_halt     = 1'b0;
`endif

    // Outstanding count once this cycle's response (if any) has retired.
    assign w_out_after = r_out - CNT_W'(w_rsp);
    assign w_credit    = ({1'b0, w_fq_count} + {1'b0, r_out}) < DEPTH_L;
    assign w_req_valid = (r_state == FETCH) && !w_redirect && w_credit && !w_halt;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;

    assign w_push = (w_rsp && (r_drop == '0) && !w_redirect) || (w_redirect && w_misalign);
    assign w_pop  = bus.instr_valid && bus.instr_ready;

    // Queue entry: the trap NOP on a misaligned redirect, otherwise the response word.
    always_comb begin
        w_push_data       = '0;
        w_push_data.pc    = r_rsp_pc;
        w_push_data.instr = bus.imem_rsp_data;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (w_redirect) begin
            w_push_data.pc       = bus.redirect_pc;
            w_push_data.instr    = NOP_INSTR;
            w_push_data.misalign = 1'b1;
        end
`endif
    end

    // Drop counter: every request still in flight at a redirect is stale.
    always_comb begin
        w_drop_nxt = r_drop;
        if (w_redirect)                      w_drop_nxt = w_out_after;
        else if (w_rsp && (r_drop != '0))    w_drop_nxt = r_drop - 1'b1;
    end

    // Next-state logic of the fetch FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = FETCH;
            FETCH:   if (w_redirect && (w_out_after != '0)) w_state_nxt = FLUSH;
            FLUSH:   if (w_drop_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = BOOT;
        endcase
    end

    // State, PC, response-PC tag, outstanding and drop counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= BOOT;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_after + CNT_W'(w_req_fire);
            r_drop  <= w_drop_nxt;
            if (w_redirect) begin
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd4;
                if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
            end
        end
    end

    fetch_queue_rv32i #(
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_fq_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.instr_valid    = !w_empty && !w_redirect;
    assign bus.instr          = w_head.instr;
    assign bus.instr_pc       = w_head.pc;
    assign bus.trimmed_instr  = w_head.instr[31:7];
    assign bus.fq_count       = w_fq_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.instr_misalign = w_head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Directed bench for fetch_unit_rv32i with a fixed-latency in-order memory
// model and a decode-side delivery monitor.
module tb_fetch_unit_rv32i;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          FQD    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_rv32i_if #(.FQ_DEPTH(FQD)) bus();

    fetch_unit_rv32i #(.RESET_PC(RST_PC), .FQ_DEPTH(FQD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory model: fixed latency lat, in order, responses cannot stall.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int cyc     = 0;
    int lat     = 1;
    int req_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
                req_cnt <= req_cnt + 1;
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= memw(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    // Decode-side monitor of completed handshakes.
    logic [31:0] d_pc[$];
    logic [31:0] d_ins[$];
    logic [24:0] d_trim[$];

    always @(posedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            d_pc.push_back(bus.instr_pc);
            d_ins.push_back(bus.instr);
            d_trim.push_back(bus.trimmed_instr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_mon();
        d_pc.delete();
        d_ins.delete();
        d_trim.delete();
    endtask

    // Reset for two edges, check the reset-state outputs, then release.
    task automatic do_reset(input int l);
        rst_n              = 1'b0;
        lat                = l;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_addr",      bus.imem_addr,            RST_PC);
        chk("rst_instr_vld", 32'(bus.instr_valid),    32'd0);
        chk("rst_fq_count",  32'(bus.fq_count),       32'd0);
        chk("rst_instr",     bus.instr,                32'd0);
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic wait_deliv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (d_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (d_pc.size() < n) chk({name, "_timeout"}, 32'(d_pc.size()), 32'(n));
    endtask

    typedef struct {
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [1:0]  exp_fq;
    } vec_t;

    vec_t tv[9];

    initial begin
        logic [31:0] e;
        int base;

        tv[0] = '{1'b0, 32'h100, 1'b0, 32'h000, 2'd0};
        tv[1] = '{1'b1, 32'h100, 1'b0, 32'h000, 2'd0};
        tv[2] = '{1'b1, 32'h104, 1'b0, 32'h000, 2'd0};
        tv[3] = '{1'b0, 32'h108, 1'b1, 32'h100, 2'd1};
        tv[4] = '{1'b1, 32'h108, 1'b1, 32'h104, 2'd1};
        tv[5] = '{1'b1, 32'h10C, 1'b0, 32'h000, 2'd0};
        tv[6] = '{1'b0, 32'h110, 1'b1, 32'h108, 2'd1};
        tv[7] = '{1'b1, 32'h110, 1'b1, 32'h10C, 2'd1};
        tv[8] = '{1'b1, 32'h114, 1'b0, 32'h000, 2'd0};

        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        @(negedge clk);

        // Streaming from reset, 1-cycle memory, cycle-exact table.
        do_reset(1);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("t1_req_valid[%0d]", i), 32'(bus.imem_req_valid), 32'(tv[i].exp_req));
            chk($sformatf("t1_addr[%0d]", i),      bus.imem_addr,            tv[i].exp_addr);
            chk($sformatf("t1_instr_vld[%0d]", i), 32'(bus.instr_valid),    32'(tv[i].exp_iv));
            chk($sformatf("t1_fq_count[%0d]", i),  32'(bus.fq_count),       32'(tv[i].exp_fq));
            if (tv[i].exp_iv) begin
                e = memw(tv[i].exp_pc);
                chk($sformatf("t1_instr_pc[%0d]", i), bus.instr_pc,              tv[i].exp_pc);
                chk($sformatf("t1_instr[%0d]", i),    bus.instr,                 e);
                chk($sformatf("t1_trim[%0d]", i),     32'(bus.trimmed_instr),    32'(e[31:7]));
            end
            tick();
        end

        // Decode stalled: credit limit caps requests at FQ_DEPTH.
        bus.instr_ready = 1'b0;
        do_reset(1);
        base = req_cnt;
        for (int i = 0; i < 10; i++) tick();
        #1;
        chk("t2_req_count",  32'(req_cnt - base),       32'(FQD));
        chk("t2_req_valid",  32'(bus.imem_req_valid),   32'd0);
        chk("t2_fq_count",   32'(bus.fq_count),         32'd2);
        chk("t2_head_pc",    bus.instr_pc,              32'h100);
        bus.instr_ready = 1'b1;
        wait_deliv(8, 100, "t2");
        for (int i = 0; i < 8 && i < d_pc.size(); i++) begin
            chk($sformatf("t2_pc[%0d]", i),    d_pc[i],  RST_PC + 32'(4 * i));
            chk($sformatf("t2_instr[%0d]", i), d_ins[i], memw(RST_PC + 32'(4 * i)));
        end

        // Redirect with two requests outstanding, 3-cycle memory.
        do_reset(3);
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        chk("t3_out_before", 32'(dut.r_out),          32'd2);
        chk("t3_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        clear_mon();
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_state_flush", 32'(dut.r_state), 32'(FLUSH));
        wait_deliv(2, 40, "t3");
        if (d_pc.size() >= 2) begin
            chk("t3_first_pc",    d_pc[0],  32'h200);
            chk("t3_first_instr", d_ins[0], memw(32'h200));
            chk("t3_second_pc",   d_pc[1],  32'h204);
        end

        // Second redirect while already flushing keeps dropping.
        do_reset(3);
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.redirect_pc    = 32'h280;
        clear_mon();
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3b_state_flush", 32'(dut.r_state), 32'(FLUSH));
        chk("t3b_drop_cnt",    32'(dut.r_drop),  32'd1);
        wait_deliv(1, 40, "t3b");
        if (d_pc.size() >= 1) chk("t3b_first_pc", d_pc[0], 32'h280);

        // Redirect coinciding with a response and a pending pop.
        do_reset(1);
        for (int i = 0; i < 6; i++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        #1;
        chk("t4_rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
        chk("t4_instr_vld",   32'(bus.instr_valid),    32'd0);
        clear_mon();
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_fq_count",  32'(bus.fq_count),       32'd0);
        chk("t4_instr_vld2", 32'(bus.instr_valid),   32'd0);
        chk("t4_state",     32'(dut.r_state),        32'(FETCH));
        chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_addr",      bus.imem_addr,           32'h300);
        wait_deliv(1, 20, "t4");
        if (d_pc.size() >= 1) begin
            chk("t4_first_pc",    d_pc[0],  32'h300);
            chk("t4_first_instr", d_ins[0], memw(32'h300));
        end

        // Random memory backpressure over 100 instructions.
        do_reset(2);
        begin
            int k;
            k = 0;
            while (d_pc.size() < 100 && k < 3000) begin
                bus.imem_req_ready = 1'($urandom_range(0, 1));
                tick();
                k++;
            end
        end
        bus.imem_req_ready = 1'b1;
        chk("t5_count", 32'(d_pc.size()), 32'd100);
        for (int i = 0; i < 100 && i < d_pc.size(); i++) begin
            e = memw(RST_PC + 32'(4 * i));
            chk($sformatf("t5_pc[%0d]", i),    d_pc[i],          RST_PC + 32'(4 * i));
            chk($sformatf("t5_instr[%0d]", i), d_ins[i],         e);
            chk($sformatf("t5_trim[%0d]", i),  32'(d_trim[i]),   32'(e[31:7]));
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect target produces one flagged NOP and halts fetch.
        bus.instr_ready = 1'b0;
        do_reset(1);
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h202;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_instr_vld", 32'(bus.instr_valid),    32'd1);
        chk("t6_instr",     bus.instr,               NOP_INSTR);
        chk("t6_misalign",  32'(bus.instr_misalign), 32'd1);
        chk("t6_pc",        bus.instr_pc,            32'h202);
        chk("t6_fq_count",  32'(bus.fq_count),       32'd1);
        base = req_cnt;
        for (int i = 0; i < 5; i++) tick();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        chk("t6_no_requests", 32'(req_cnt - base),     32'd0);
        chk("t6_drained",     32'(bus.fq_count),       32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_resume_req",  32'(bus.imem_req_valid), 32'd1);
        chk("t6_resume_addr", bus.imem_addr,           32'h400);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
